crono_cuenta_regresiva: RTL
===========================

Name: crono_cuenta_regresiva

Overview:
Countdown core for the chronometer, directly downstream of the chronometer control/programming FSM. It loads the programmed hours/minutes/seconds and decrements them once per second while the control FSM holds CronoActivo high. It returns FinalizoCrono to that FSM when the count reaches 00:00:00. The live count goes to the display/readout path.

Parameters:
TICKS_POR_SEG, 100000000, clk cycles per one-second decrement (benches use 4)
HORAS_MAX, 8'h23, maximum legal hours value in BCD

Ports:
clk  input  1  system clock, all logic on rising edge
Reset  input  1  asynchronous, active-high reset
ProgramarCrono  input  1  level; while high, counter tracks preset inputs
CronoActivo  input  1  level; high = count down, low = pause
horasIn  input  8  preset hours, BCD
minutosIn  input  8  preset minutes, BCD
segundosIn  input  8  preset seconds, BCD
horasCnt  output  8  current hours, BCD
minutosCnt  output  8  current minutes, BCD
segundosCnt  output  8  current seconds, BCD
FinalizoCrono  output  1  level; high while in FINALIZADO
tick_seg  output  1  one-cycle pulse on each decrement edge

Behaviour:
- One clock (clk). Reset is asynchronous and active-high.
- Reset, async:
  - state=ESPERA; horasCnt/minutosCnt/segundosCnt=8'h00; prescaler=0.
  - FinalizoCrono=0; tick_seg=0.
  - Applies mid-count with no partial update.
- States: CARGA, ESPERA, CORRIENDO, FINALIZADO. All outputs are registered.
- Priority each edge: ProgramarCrono > state rules.
  - ProgramarCrono=1 from any state -> CARGA.
- CARGA:
  - Every edge: counters <= clamped presets; prescaler <= 0; FinalizoCrono <= 0.
  - ProgramarCrono=0 -> ESPERA with the last loaded value held.
- Clamping, per field at load:
  - Any nibble >9, or tens digit over the field limit, is replaced by the field maximum.
  - Field maxima: 8'h59 for minutes/seconds, HORAS_MAX for hours.
  - Example: 8'h7A -> 8'h59 for seconds; 8'h25 -> 8'h23 for hours.
- ESPERA:
  - Counters and prescaler hold.
  - CronoActivo=1 with count !=000000 -> CORRIENDO.
  - CronoActivo=1 with count ==000000 -> FINALIZADO next edge, FinalizoCrono=1, no tick.
- CORRIENDO:
  - Prescaler increments each cycle, 0..TICKS_POR_SEG-1.
  - On the edge where prescaler==TICKS_POR_SEG-1: prescaler<=0, tick_seg<=1 for one cycle, count decrements by one second.
  - CronoActivo=0 -> ESPERA; prescaler value is kept, so a pause preserves the fractional second.
- BCD decrement rules:
  - Seconds units 0 -> 9 with borrow from tens.
  - Seconds 00 -> 59 with borrow from minutes.
  - Minutes 00 -> 59 with borrow from hours.
  - Hours never underflow, because 00:00:00 stops the count.
- Terminal:
  - When a decrement produces 00:00:00, the same edge sets state=FINALIZADO and FinalizoCrono=1.
  - The counters and FinalizoCrono change on the same edge, with zero extra latency.
- FINALIZADO:
  - Counters stay at 00; prescaler=0; FinalizoCrono held at 1.
  - CronoActivo is ignored.
  - Exit only via ProgramarCrono=1 (-> CARGA, FinalizoCrono cleared on that edge) or Reset.
- Simultaneous events:
  - ProgramarCrono=1 on a tick edge: load wins; no decrement; tick_seg=0.
  - CronoActivo falling on a tick edge: the decrement still occurs, then the block enters ESPERA.
- tick_seg is 0 in every state except CORRIENDO.

Test Plan:
- Reset async assert mid-CORRIENDO at 00:00:05 -> counters 00:00:00, FinalizoCrono=0, state ESPERA, all without waiting for a clk edge.
- TICKS_POR_SEG=4: load 00:00:03, ProgramarCrono low, CronoActivo high -> tick_seg every 4 cycles, count 02, 01, 00. FinalizoCrono=1 on the same edge as 00. It stays 1 after CronoActivo drops and clears on the first ProgramarCrono edge.
- Borrow chain: load 01:00:00, run one tick -> 00:59:59. Load 00:10:00, one tick -> 00:09:59.
- Pause preserves prescaler: run 2 cycles, CronoActivo low 10 cycles, high again -> next decrement after 2 more cycles, not 4.
- Clamp: load horasIn=8'h25, minutosIn=8'h6A, segundosIn=8'hF3 -> 23:59:59. Load 00:00:00 then CronoActivo=1 -> FinalizoCrono=1 next edge, tick_seg never pulses.
- Collisions: ProgramarCrono=1 on a tick edge with preset 00:00:09 -> count 00:00:09, tick_seg=0. CronoActivo drop on a tick edge at 00:00:04 -> 00:00:03 then ESPERA.

Source files
------------

// File: rtl/crono_cuenta_regresiva.sv
// Chronometer countdown core: loads a clamped BCD preset and counts
// down once per second while enabled, flagging the 00:00:00 terminal.
module crono_cuenta_regresiva #(
    parameter int          TICKS_POR_SEG = 100000000,
    parameter logic [7:0]  HORAS_MAX     = 8'h23
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       ProgramarCrono,
    input  logic       CronoActivo,
    input  logic [7:0] horasIn,
    input  logic [7:0] minutosIn,
    input  logic [7:0] segundosIn,
    output logic [7:0] horasCnt,
    output logic [7:0] minutosCnt,
    output logic [7:0] segundosCnt,
    output logic       FinalizoCrono,
    output logic       tick_seg
);

    localparam int PW = (TICKS_POR_SEG > 1) ? $clog2(TICKS_POR_SEG) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_POR_SEG - 1);

    typedef enum logic [1:0] {
        CARGA,
        ESPERA,
        CORRIENDO,
        FINALIZADO
    } estado_t;

    estado_t       estado;
    logic [PW-1:0] prescaler;

    logic [7:0] h_next;
    logic [7:0] m_next;
    logic [7:0] s_next;
    logic       cuenta_cero;
    logic       next_cero;

    // Illegal BCD digits or out-of-range values saturate to the field maximum
    function automatic logic [7:0] clamp(input logic [7:0] v,
                                         input logic [7:0] vmax);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > vmax)
            return vmax;
        return v;
    endfunction

    function automatic logic [7:0] dec_bcd(input logic [7:0] v,
                                           input logic [7:0] wrap);
        if (v == 8'h00)
            return wrap;
        if (v[3:0] != 4'd0)
            return {v[7:4], v[3:0] - 4'd1};
        return {v[7:4] - 4'd1, 4'd9};
    endfunction

    always_comb begin
        s_next = dec_bcd(segundosCnt, 8'h59);
        m_next = minutosCnt;
        h_next = horasCnt;
        if (segundosCnt == 8'h00)
            m_next = dec_bcd(minutosCnt, 8'h59);
        if (segundosCnt == 8'h00 && minutosCnt == 8'h00)
            h_next = dec_bcd(horasCnt, 8'h00);
    end

    assign cuenta_cero = {horasCnt, minutosCnt, segundosCnt} == 24'h0;
    assign next_cero   = {h_next, m_next, s_next} == 24'h0;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            estado        <= ESPERA;
            horasCnt      <= 8'h00;
            minutosCnt    <= 8'h00;
            segundosCnt   <= 8'h00;
            prescaler     <= '0;
            FinalizoCrono <= 1'b0;
            tick_seg      <= 1'b0;
        end else begin
            tick_seg <= 1'b0;
            if (ProgramarCrono) begin
                estado        <= CARGA;
                horasCnt      <= clamp(horasIn, HORAS_MAX);
                minutosCnt    <= clamp(minutosIn, 8'h59);
                segundosCnt   <= clamp(segundosIn, 8'h59);
                prescaler     <= '0;
                FinalizoCrono <= 1'b0;
            end else begin
                case (estado)
                    CARGA: begin
                        estado <= ESPERA;
                    end
                    ESPERA: begin
                        if (CronoActivo) begin
                            if (cuenta_cero) begin
                                estado        <= FINALIZADO;
                                FinalizoCrono <= 1'b1;
                                prescaler     <= '0;
                            end else begin
                                estado <= CORRIENDO;
                            end
                        end
                    end
                    CORRIENDO: begin
                        // A pausing edge still advances, so no fraction is lost
                        if (prescaler == PRE_MAX) begin
                            prescaler   <= '0;
                            tick_seg    <= 1'b1;
                            horasCnt    <= h_next;
                            minutosCnt  <= m_next;
                            segundosCnt <= s_next;
                            if (next_cero) begin
                                estado        <= FINALIZADO;
                                FinalizoCrono <= 1'b1;
                            end else if (!CronoActivo) begin
                                estado <= ESPERA;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                            if (!CronoActivo)
                                estado <= ESPERA;
                        end
                    end
                    FINALIZADO: begin
                        prescaler     <= '0;
                        FinalizoCrono <= 1'b1;
                    end
                    default: begin
                        estado <= ESPERA;
                    end
                endcase
            end
        end
    end

endmodule
